// File: rtl/bp_pkg.sv
// Shared types, counter encodings and PC slicing helpers for the branch predictor.
// Table entries hold tag/target at BP_XLEN width; narrower XLEN values are zero-extended.
package bp_pkg;

   localparam int BP_XLEN = 32;

   localparam logic [1:0] CTR_SNT   = 2'b00;
   localparam logic [1:0] CTR_WNT   = 2'b01;
   localparam logic [1:0] CTR_WT    = 2'b10;
   localparam logic [1:0] CTR_ST    = 2'b11;
   localparam logic [1:0] CTR_RESET = CTR_WNT;

   typedef struct packed {
      logic               valid;
      logic [BP_XLEN-1:0] tag;
      logic [BP_XLEN-1:0] target;
      logic [1:0]         ctr;
   } btb_entry_t;

   function automatic logic [BP_XLEN-1:0] bp_index(input logic [BP_XLEN-1:0] pc, input int idx_bits);
      return (pc >> 2) & ((BP_XLEN'(1) << idx_bits) - BP_XLEN'(1));
   endfunction

   function automatic logic [BP_XLEN-1:0] bp_tag(input logic [BP_XLEN-1:0] pc, input int idx_bits);
      return pc >> (idx_bits + 2);
   endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state logic for branch direction history.
// Purely combinational, zero latency; no flow control.
module bp_sat_counter
   import bp_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       taken,
   output logic [1:0] ctr_next
);

   always_comb begin
      ctr_next = ctr;
      if (taken) begin
         if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage 2-bit predictor with direct-mapped BTB; lookup is zero-latency, update lands at the next edge.
// No backpressure: one lookup and one update per cycle. Optional stats counters under BP_STATS_EN.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] PCF,
   output logic            PredTakenF,
   output logic [XLEN-1:0] PredTargetF,
   input  logic            UpdateE,
   input  logic [XLEN-1:0] PCE,
   input  logic            TakenE,
   input  logic [XLEN-1:0] TargetE,
   input  logic            PredTakenE,
   input  logic [XLEN-1:0] PredTargetE,
   output logic            MispredictE,
   output logic [XLEN-1:0] RedirectPCE,
   output logic [31:0]     BranchCount,
   output logic [31:0]     MispredCount
);

   localparam int DEPTH = 1 << IDX_BITS;

   // Flop array rather than SRAM so that a single reset cycle clears every entry.
   btb_entry_t table_q [DEPTH];

   logic [BP_XLEN-1:0]  pcf_w;
   logic [BP_XLEN-1:0]  pce_w;
   logic [IDX_BITS-1:0] idx_f;
   logic [IDX_BITS-1:0] idx_e;
   logic                hit_f;
   logic                hit_e;
   logic [1:0]          ctr_next;

   assign pcf_w = BP_XLEN'(PCF);
   assign pce_w = BP_XLEN'(PCE);
   assign idx_f = IDX_BITS'(bp_index(pcf_w, IDX_BITS));
   assign idx_e = IDX_BITS'(bp_index(pce_w, IDX_BITS));

   assign hit_f = table_q[idx_f].valid && (table_q[idx_f].tag == bp_tag(pcf_w, IDX_BITS));
   assign hit_e = table_q[idx_e].valid && (table_q[idx_e].tag == bp_tag(pce_w, IDX_BITS));

   assign PredTakenF  = hit_f && table_q[idx_f].ctr[1];
   assign PredTargetF = hit_f ? XLEN'(table_q[idx_f].target) : PCF + XLEN'(4);

   bp_sat_counter u_sat_counter (
      .ctr      (table_q[idx_e].ctr),
      .taken    (TakenE),
      .ctr_next (ctr_next)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_RESET};
         end
      end else if (UpdateE) begin
         if (hit_e) begin
            table_q[idx_e].ctr <= ctr_next;
            if (TakenE) table_q[idx_e].target <= BP_XLEN'(TargetE);
         end else if (TakenE) begin
            // Allocation evicts whatever alias currently owns this index.
            table_q[idx_e] <= '{valid:  1'b1,
                                tag:    bp_tag(pce_w, IDX_BITS),
                                target: BP_XLEN'(TargetE),
                                ctr:    CTR_WT};
         end
      end
   end

   assign MispredictE = UpdateE &&
                        ((PredTakenE != TakenE) ||
                         (TakenE && PredTakenE && (PredTargetE != TargetE)));
   assign RedirectPCE = TakenE ? TargetE : PCE + XLEN'(4);

`ifdef BP_STATS_EN
   logic [31:0] branch_cnt_q;
   logic [31:0] mispred_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (UpdateE)     branch_cnt_q  <= branch_cnt_q + 32'd1;
         if (MispredictE) mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
   end

   assign BranchCount  = branch_cnt_q;
   assign MispredCount = mispred_cnt_q;
`else
   assign BranchCount  = '0;
   assign MispredCount = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed plan scenarios plus randomized traffic
// against a table-of-arrays reference model.
module tb_branch_predictor;

   localparam int IDX   = 6;
   localparam int N     = 64;
   localparam int TAGSH = IDX + 2;

   logic        clk;
   logic        rst;
   logic [31:0] PCF;
   logic        PredTakenF;
   logic [31:0] PredTargetF;
   logic        UpdateE;
   logic [31:0] PCE;
   logic        TakenE;
   logic [31:0] TargetE;
   logic        PredTakenE;
   logic [31:0] PredTargetE;
   logic        MispredictE;
   logic [31:0] RedirectPCE;
   logic [31:0] BranchCount;
   logic [31:0] MispredCount;

   int vectors;
   int miscompares;

   branch_predictor #(.IDX_BITS(IDX), .XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .PCF         (PCF),
      .PredTakenF  (PredTakenF),
      .PredTargetF (PredTargetF),
      .UpdateE     (UpdateE),
      .PCE         (PCE),
      .TakenE      (TakenE),
      .TargetE     (TargetE),
      .PredTakenE  (PredTakenE),
      .PredTargetE (PredTargetE),
      .MispredictE (MispredictE),
      .RedirectPCE (RedirectPCE),
      .BranchCount (BranchCount),
      .MispredCount(MispredCount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: one slot per index, counter kept as an integer 0..3.
   bit          m_valid [N];
   logic [31:0] m_tag   [N];
   logic [31:0] m_tgt   [N];
   int          m_ctr   [N];
   logic [31:0] m_bcnt;
   logic [31:0] m_mcnt;

   function automatic int m_index(logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      return m_valid[m_index(pc)] && (m_tag[m_index(pc)] == (pc >> TAGSH));
   endfunction

   function automatic logic m_pred_taken(logic [31:0] pc);
      return m_hit(pc) && (m_ctr[m_index(pc)] >= 2);
   endfunction

   function automatic logic [31:0] m_pred_target(logic [31:0] pc);
      return m_hit(pc) ? m_tgt[m_index(pc)] : pc + 32'd4;
   endfunction

   function automatic logic exp_mispred();
      bit wrong_dir;
      bit wrong_tgt;
      wrong_dir = (PredTakenE != TakenE);
      wrong_tgt = TakenE && PredTakenE && (PredTargetE != TargetE);
      return UpdateE && (wrong_dir || wrong_tgt);
   endfunction

   function automatic logic [31:0] exp_stat(logic [31:0] cnt);
`ifdef BP_STATS_EN
      return cnt;
`else
      return (cnt & 32'd0);
`endif
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_tgt[i]   = '0;
         m_ctr[i]   = 1;
      end
      m_bcnt = '0;
      m_mcnt = '0;
   endtask

   task automatic m_update(logic [31:0] pc, logic taken, logic [31:0] tgt);
      int i;
      i = m_index(pc);
      if (m_hit(pc)) begin
         if (taken) begin
            if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
            m_tgt[i] = tgt;
         end else if (m_ctr[i] > 0) begin
            m_ctr[i] = m_ctr[i] - 1;
         end
      end else if (taken) begin
         m_valid[i] = 1'b1;
         m_tag[i]   = pc >> TAGSH;
         m_tgt[i]   = tgt;
         m_ctr[i]   = 2;
      end
   endtask

   task automatic drive_upd(logic u, logic [31:0] pce, logic taken, logic [31:0] tgt,
                            logic pte, logic [31:0] ptgt);
      UpdateE     = u;
      PCE         = pce;
      TakenE      = taken;
      TargetE     = tgt;
      PredTakenE  = pte;
      PredTargetE = ptgt;
   endtask

   task automatic drive_idle();
      drive_upd(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   // Advance the model with the currently driven inputs, then take the clock edge.
   task automatic clk_edge();
      if (rst) begin
         m_reset();
      end else if (UpdateE) begin
         m_bcnt = m_bcnt + 32'd1;
         if (exp_mispred()) m_mcnt = m_mcnt + 32'd1;
         m_update(PCE, TakenE, TargetE);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rand_pc();
      logic [31:0] hi;
      hi = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 3));
      return (hi << TAGSH) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      drive_idle();
      clk_edge();
      rst = 1'b0;
      PCF = 32'h0000_0040;
      #1;
      vectors++;
      if (PredTakenF !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_taken: got %0b want 0", PredTakenF);
      end
      vectors++;
      if (PredTargetF !== 32'h0000_0044) begin
         miscompares++;
         $display("FAIL reset_target: got %08h want 00000044", PredTargetF);
      end
      vectors++;
      if (MispredictE !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mispred: got %0b want 0", MispredictE);
      end
      vectors++;
      if (BranchCount !== 32'd0 || MispredCount !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_stats: got %0d/%0d want 0/0", BranchCount, MispredCount);
      end
   endtask

   task automatic test_cold_taken();
      PCF = 32'h0000_0040;
      drive_upd(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0044);
      #1;
      vectors++;
      if (MispredictE !== 1'b1 || RedirectPCE !== 32'h0000_0100) begin
         miscompares++;
         $display("FAIL cold_mispred: got %0b/%08h want 1/00000100", MispredictE, RedirectPCE);
      end
      clk_edge();
      drive_idle();
      #1;
      vectors++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h0000_0100) begin
         miscompares++;
         $display("FAIL cold_lookup: got %0b/%08h want 1/00000100", PredTakenF, PredTargetF);
      end
      vectors++;
      if (MispredictE !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_mispred: got %0b want 0", MispredictE);
      end
   endtask

   task automatic test_saturation();
      PCF = 32'h0000_0040;
      for (int k = 0; k < 3; k++) begin
         drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
         #1;
         vectors++;
         if (MispredictE !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_taken_%0d: mispred got %0b want 0", k, MispredictE);
         end
         clk_edge();
      end
      drive_upd(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
      #1;
      vectors++;
      if (MispredictE !== 1'b1 || RedirectPCE !== 32'h0000_0044) begin
         miscompares++;
         $display("FAIL sat_nt1_mispred: got %0b/%08h want 1/00000044", MispredictE, RedirectPCE);
      end
      clk_edge();
      drive_idle();
      #1;
      vectors++;
      if (PredTakenF !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_hyst_strong: got %0b want 1", PredTakenF);
      end
      drive_upd(1'b1, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100);
      clk_edge();
      drive_idle();
      #1;
      vectors++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0000_0100) begin
         miscompares++;
         $display("FAIL sat_weak_nt: got %0b/%08h want 0/00000100", PredTakenF, PredTargetF);
      end
      for (int k = 0; k < 2; k++) begin
         drive_upd(1'b1, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44);
         clk_edge();
      end
      // One taken from a held 00 must only reach 01.
      drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h100);
      clk_edge();
      drive_idle();
      #1;
      vectors++;
      if (PredTakenF !== 1'b0) begin
         miscompares++;
         $display("FAIL sat_floor: got %0b want 0", PredTakenF);
      end
      drive_upd(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h100);
      clk_edge();
      drive_idle();
      #1;
      vectors++;
      if (PredTakenF !== 1'b1) begin
         miscompares++;
         $display("FAIL sat_recover: got %0b want 1", PredTakenF);
      end
   endtask

   task automatic test_aliasing();
      drive_upd(1'b1, 32'h0000_0140, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0144);
      clk_edge();
      drive_idle();
      PCF = 32'h0000_0040;
      #1;
      vectors++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0000_0044) begin
         miscompares++;
         $display("FAIL alias_evicted: got %0b/%08h want 0/00000044", PredTakenF, PredTargetF);
      end
      PCF = 32'h0000_0140;
      #1;
      vectors++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h0000_0100) begin
         miscompares++;
         $display("FAIL alias_new: got %0b/%08h want 1/00000100", PredTakenF, PredTargetF);
      end
   endtask

   task automatic test_wrong_target();
      drive_upd(1'b1, 32'h0000_0140, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0100);
      #1;
      vectors++;
      if (MispredictE !== 1'b1 || RedirectPCE !== 32'h0000_0200) begin
         miscompares++;
         $display("FAIL wrong_tgt_mispred: got %0b/%08h want 1/00000200", MispredictE, RedirectPCE);
      end
      clk_edge();
      drive_idle();
      PCF = 32'h0000_0140;
      #1;
      vectors++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h0000_0200) begin
         miscompares++;
         $display("FAIL wrong_tgt_stored: got %0b/%08h want 1/00000200", PredTakenF, PredTargetF);
      end
   endtask

   task automatic test_stats();
      #1;
      vectors++;
      if (BranchCount !== exp_stat(m_bcnt) || MispredCount !== exp_stat(m_mcnt)) begin
         miscompares++;
         $display("FAIL stats: got %0d/%0d want %0d/%0d",
                  BranchCount, MispredCount, exp_stat(m_bcnt), exp_stat(m_mcnt));
      end
   endtask

   task automatic test_same_cycle();
      PCF = 32'h0000_0040;
      drive_upd(1'b1, 32'h0000_0040, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0044);
      #3;
      vectors++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0000_0044) begin
         miscompares++;
         $display("FAIL same_cycle_old: got %0b/%08h want 0/00000044", PredTakenF, PredTargetF);
      end
      clk_edge();
      drive_idle();
      #1;
      vectors++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h0000_0300) begin
         miscompares++;
         $display("FAIL same_cycle_next: got %0b/%08h want 1/00000300", PredTakenF, PredTargetF);
      end
   endtask

   task automatic test_boundary();
      drive_upd(1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_0010, 1'b1, 32'h0000_0010);
      #1;
      vectors++;
      if (MispredictE !== 1'b1 || RedirectPCE !== 32'h0000_0000) begin
         miscompares++;
         $display("FAIL wrap_redirect: got %0b/%08h want 1/00000000", MispredictE, RedirectPCE);
      end
      clk_edge();
      drive_idle();
      PCF = 32'hFFFF_FFFC;
      #1;
      vectors++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0000_0000) begin
         miscompares++;
         $display("FAIL wrap_lookup: got %0b/%08h want 0/00000000", PredTakenF, PredTargetF);
      end
      drive_upd(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000);
      clk_edge();
      drive_idle();
      PCF = 32'hFFFF_FFFF;
      #1;
      vectors++;
      if (PredTakenF !== 1'b1 || PredTargetF !== 32'h0000_0010) begin
         miscompares++;
         $display("FAIL low_bits_ignored: got %0b/%08h want 1/00000010", PredTakenF, PredTargetF);
      end
   endtask

   task automatic test_reset_with_update();
      rst = 1'b1;
      drive_upd(1'b1, 32'h0000_0080, 1'b1, 32'h0000_0500, 1'b0, 32'h0000_0084);
      clk_edge();
      rst = 1'b0;
      drive_idle();
      PCF = 32'h0000_0080;
      #1;
      vectors++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0000_0084) begin
         miscompares++;
         $display("FAIL rst_drops_update: got %0b/%08h want 0/00000084", PredTakenF, PredTargetF);
      end
      PCF = 32'h0000_0040;
      #1;
      vectors++;
      if (PredTakenF !== 1'b0 || PredTargetF !== 32'h0000_0044) begin
         miscompares++;
         $display("FAIL rst_clears_table: got %0b/%08h want 0/00000044", PredTakenF, PredTargetF);
      end
      vectors++;
      if (BranchCount !== 32'd0 || MispredCount !== 32'd0) begin
         miscompares++;
         $display("FAIL rst_clears_stats: got %0d/%0d want 0/0", BranchCount, MispredCount);
      end
   endtask

   task automatic test_random();
      logic [31:0] pcf;
      logic [31:0] pce;
      logic [31:0] tgt;
      logic        taken;
      for (int it = 0; it < 400; it++) begin
         pcf   = rand_pc();
         pce   = rand_pc();
         taken = 1'($urandom_range(0, 1));
         tgt   = 32'($urandom_range(0, 255)) << 2;
         rst   = ($urandom_range(0, 39) == 0);
         PCF   = pcf;
         drive_upd(($urandom_range(0, 3) != 0), pce, taken, tgt,
                   ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : m_pred_taken(pce),
                   ($urandom_range(0, 3) == 0) ? (32'($urandom_range(0, 255)) << 2)
                                               : m_pred_target(pce));
         #1;
         vectors++;
         if (PredTakenF !== m_pred_taken(pcf) || PredTargetF !== m_pred_target(pcf)) begin
            miscompares++;
            $display("FAIL rand_lookup it=%0d pc=%08h: got %0b/%08h want %0b/%08h", it, pcf,
                     PredTakenF, PredTargetF, m_pred_taken(pcf), m_pred_target(pcf));
         end
         vectors++;
         if (MispredictE !== exp_mispred()) begin
            miscompares++;
            $display("FAIL rand_mispred it=%0d: got %0b want %0b", it, MispredictE, exp_mispred());
         end
         if (exp_mispred()) begin
            vectors++;
            if (RedirectPCE !== (taken ? tgt : pce + 32'd4)) begin
               miscompares++;
               $display("FAIL rand_redirect it=%0d: got %08h want %08h", it, RedirectPCE,
                        taken ? tgt : pce + 32'd4);
            end
         end
         clk_edge();
      end
      rst = 1'b0;
      drive_idle();
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      PCF         = '0;
      drive_idle();
      m_reset();
      test_reset();
      test_cold_taken();
      test_saturation();
      test_aliasing();
      test_wrong_target();
      test_stats();
      test_same_cycle();
      test_boundary();
      test_reset_with_update();
      test_random();
      test_stats();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
